// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the 16-bit,
//   4-bit-opcode core. Drives a synchronous-read (1-cycle latency)
//   instruction memory, sequences the PC, and keeps a one-entry skid
//   buffer so a response arriving during a stall is never lost. Taken
//   branches squash everything in flight. The HALT opcode (4'hF) stops
//   fetch until reset.
//
// Parameters
//   ADDR_WIDTH    : instruction word-address width (PC width)
//   RESET_PC      : PC loaded on reset
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous, active-high
//   stall         : decode cannot accept; IF/ID and PC hold
//   branch_taken  : redirect fetch to branch_target (overrides stall)
//   branch_target : redirect address
//   imem_en       : memory read request this cycle
//   imem_addr     : memory read address (the PC register)
//   imem_rdata    : word for the address requested in the previous cycle
//   if_id_valid   : IF/ID holds a live instruction
//   if_id_instr   : fetched instruction
//   if_id_pc      : address of if_id_instr
//   opcode        : if_id_instr[15:12]
//   reg_rt_id     : if_id_instr[3:0] (also the REGIMM sub-function)
//   halted        : sticky, set when HALT reaches IF/ID
module fetch_stage #(
    parameter int unsigned                ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [15:0]           imem_rdata,
    output logic                  if_id_valid,
    output logic [15:0]           if_id_instr,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic [3:0]            opcode,
    output logic [3:0]            reg_rt_id,
    output logic                  halted
);

    localparam logic [3:0] OP_HALT = 4'hF;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  f_valid;
    logic [ADDR_WIDTH-1:0] f_pc;
    logic                  sk_valid;
    logic [15:0]           sk_instr;
    logic [ADDR_WIDTH-1:0] sk_pc;

    // Candidate word for IF/ID: the skid entry is older than any response,
    // so it always wins. Both cannot be live at once because nothing issues
    // while stalled.
    logic                  fill_valid;
    logic [15:0]           fill_instr;
    logic [ADDR_WIDTH-1:0] fill_pc;

    always_comb begin
        fill_valid = sk_valid | f_valid;
        fill_instr = sk_valid ? sk_instr : imem_rdata;
        fill_pc    = sk_valid ? sk_pc    : f_pc;
    end

    assign imem_en   = ~reset & ~stall & ~branch_taken & ~halted;
    assign imem_addr = pc;
    assign opcode    = if_id_instr[15:12];
    assign reg_rt_id = if_id_instr[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            f_valid     <= 1'b0;
            f_pc        <= '0;
            sk_valid    <= 1'b0;
            sk_instr    <= '0;
            sk_pc       <= '0;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            halted      <= 1'b0;
        end else begin
            if (imem_en) begin
                pc      <= pc + 1'b1;
                f_valid <= 1'b1;
                f_pc    <= pc;
            end else begin
                f_valid <= 1'b0;
            end

            if (halted) begin
                // HALT stays presented until decode takes it, then bubbles.
                // Branches are ignored from here until reset.
                if (!stall) begin
                    if_id_valid <= 1'b0;
                end
                sk_valid <= 1'b0;
            end else if (branch_taken) begin
                pc          <= branch_target;
                if_id_valid <= 1'b0;
                sk_valid    <= 1'b0;
                f_valid     <= 1'b0;
            end else if (stall) begin
                if (f_valid) begin
                    sk_valid <= 1'b1;
                    sk_instr <= imem_rdata;
                    sk_pc    <= f_pc;
                end
            end else if (fill_valid) begin
                if_id_valid <= 1'b1;
                if_id_instr <= fill_instr;
                if_id_pc    <= fill_pc;
                sk_valid    <= 1'b0;
                if (fill_instr[15:12] == OP_HALT) begin
                    halted  <= 1'b1;
                    // Drop the request issued alongside the HALT load.
                    f_valid <= 1'b0;
                end
            end else begin
                if_id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage with ADDR_WIDTH=8, RESET_PC=0. A
//   behavioural synchronous-read memory returns mem[addr] one cycle after
//   a request. Default memory word at address a is 16'h2000 | a, except
//   addresses 0..2 (0x0123, 0x3456, 0x7ABC) and, late in the run, a HALT
//   word at address 3. Inputs are driven and outputs sampled on the
//   falling edge; "cycle N" below counts falling edges after the first
//   cycle with reset low.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        if_id_valid;
    logic [15:0] if_id_instr;
    logic [7:0]  if_id_pc;
    logic [3:0]  opcode;
    logic [3:0]  reg_rt_id;
    logic        halted;

    logic [15:0] mem [256];

    int checks;
    int errors;

    fetch_stage #(
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .opcode        (opcode),
        .reg_rt_id     (reg_rt_id),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial imem_rdata = '0;
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ifid(input string tag, input logic v, input logic [7:0] p, input logic [15:0] w);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'(v));
        chk({tag, "_pc"},    32'(if_id_pc),    32'(p));
        chk({tag, "_instr"}, 32'(if_id_instr), 32'(w));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000 | 16'(i);
        mem[0] = 16'h0123;
        mem[1] = 16'h3456;
        mem[2] = 16'h7ABC;

        // Reset state
        cyc();
        chk("rst_valid",  32'(if_id_valid), 32'h0);
        chk("rst_halted", 32'(halted),      32'h0);
        chk("rst_en",     32'(imem_en),     32'h0);
        chk("rst_addr",   32'(imem_addr),   32'h00);
        chk("rst_instr",  32'(if_id_instr), 32'h0000);
        chk("rst_pc",     32'(if_id_pc),    32'h00);

        // Cycle 0: first request at RESET_PC
        cyc(); reset = 1'b0; #1;
        chk("c0_en",   32'(imem_en),   32'h1);
        chk("c0_addr", 32'(imem_addr), 32'h00);
        cyc();
        chk("c1_valid", 32'(if_id_valid), 32'h0);
        chk("c1_addr",  32'(imem_addr),   32'h01);
        cyc();
        ifid("c2", 1'b1, 8'h00, 16'h0123);
        chk("c2_op", 32'(opcode), 32'h0); chk("c2_rt", 32'(reg_rt_id), 32'h3);
        cyc();
        ifid("c3", 1'b1, 8'h01, 16'h3456);
        chk("c3_op", 32'(opcode), 32'h3); chk("c3_rt", 32'(reg_rt_id), 32'h6);
        cyc();
        ifid("c4", 1'b1, 8'h02, 16'h7ABC);
        chk("c4_op", 32'(opcode), 32'h7); chk("c4_rt", 32'(reg_rt_id), 32'hC);

        // 3-cycle stall with pc4 response in flight
        cyc();
        ifid("c5", 1'b1, 8'h03, 16'h2003);
        chk("c5_addr", 32'(imem_addr), 32'h05);
        stall = 1'b1; #1;
        chk("c5_en_stall", 32'(imem_en), 32'h0);
        cyc(); ifid("st6", 1'b1, 8'h03, 16'h2003);
        chk("st6_addr", 32'(imem_addr), 32'h05);
        cyc(); ifid("st7", 1'b1, 8'h03, 16'h2003);
        cyc(); ifid("st8", 1'b1, 8'h03, 16'h2003);
        stall = 1'b0; #1;
        chk("c8_en",   32'(imem_en),   32'h1);
        chk("c8_addr", 32'(imem_addr), 32'h05);

        // Skid word first, then branch with stall to 0x40
        cyc();
        ifid("c9", 1'b1, 8'h04, 16'h2004);
        chk("c9_addr", 32'(imem_addr), 32'h06);
        stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40; #1;
        chk("c9_en_br", 32'(imem_en), 32'h0);
        cyc();
        stall = 1'b0; branch_taken = 1'b0;
        chk("c10_bubble", 32'(if_id_valid), 32'h0);
        chk("c10_addr",   32'(imem_addr),   32'h40);
        #1; chk("c10_en", 32'(imem_en), 32'h1);
        cyc();
        chk("c11_bubble", 32'(if_id_valid), 32'h0);
        chk("c11_addr",   32'(imem_addr),   32'h41);
        cyc(); ifid("c12", 1'b1, 8'h40, 16'h2040);
        cyc(); ifid("c13", 1'b1, 8'h41, 16'h2041);

        // Branch to 0xFE and watch the PC wrap
        branch_taken = 1'b1; branch_target = 8'hFE;
        cyc(); branch_taken = 1'b0;
        chk("c14_bubble", 32'(if_id_valid), 32'h0);
        chk("c14_addr",   32'(imem_addr),   32'hFE);
        cyc();
        chk("c15_bubble", 32'(if_id_valid), 32'h0);
        chk("c15_addr",   32'(imem_addr),   32'hFF);
        cyc(); ifid("w16", 1'b1, 8'hFE, 16'h20FE);
        cyc(); ifid("w17", 1'b1, 8'hFF, 16'h20FF);
        chk("w17_addr", 32'(imem_addr), 32'h01);
        cyc(); ifid("w18", 1'b1, 8'h00, 16'h0123);
        cyc(); ifid("w19", 1'b1, 8'h01, 16'h3456);
        cyc(); ifid("w20", 1'b1, 8'h02, 16'h7ABC);

        // Stall so pc3 lands in the skid buffer, then reset mid-stall
        stall = 1'b1;
        cyc(); ifid("c21", 1'b1, 8'h02, 16'h7ABC);
        reset = 1'b1; #1;
        chk("c21_en_rst", 32'(imem_en), 32'h0);
        cyc();
        chk("r22_valid",  32'(if_id_valid), 32'h0);
        chk("r22_halted", 32'(halted),      32'h0);
        chk("r22_addr",   32'(imem_addr),   32'h00);
        chk("r22_pc",     32'(if_id_pc),    32'h00);
        chk("r22_instr",  32'(if_id_instr), 32'h0000);
        reset = 1'b0; stall = 1'b0; mem[3] = 16'hF000; #1;
        chk("r22_en", 32'(imem_en), 32'h1);
        cyc(); chk("r23_valid", 32'(if_id_valid), 32'h0);
        cyc(); ifid("r24", 1'b1, 8'h00, 16'h0123);
        cyc(); ifid("r25", 1'b1, 8'h01, 16'h3456);
        cyc(); ifid("r26", 1'b1, 8'h02, 16'h7ABC);
        chk("r26_halted", 32'(halted), 32'h0);

        // HALT at address 3, held by a 2-cycle stall
        cyc(); ifid("h27", 1'b1, 8'h03, 16'hF000);
        chk("h27_halted", 32'(halted),    32'h1);
        chk("h27_op",     32'(opcode),    32'hF);
        chk("h27_addr",   32'(imem_addr), 32'h05);
        chk("h27_en",     32'(imem_en),   32'h0);
        stall = 1'b1;
        cyc(); ifid("h28", 1'b1, 8'h03, 16'hF000);
        cyc(); ifid("h29", 1'b1, 8'h03, 16'hF000);
        stall = 1'b0; #1;
        chk("h29_en", 32'(imem_en), 32'h0);
        cyc();
        chk("h30_valid",  32'(if_id_valid), 32'h0);
        chk("h30_halted", 32'(halted),      32'h1);
        branch_taken = 1'b1; branch_target = 8'h10; #1;
        chk("h30_en_br", 32'(imem_en), 32'h0);
        cyc(); branch_taken = 1'b0;
        chk("h31_valid",  32'(if_id_valid), 32'h0);
        chk("h31_addr",   32'(imem_addr),   32'h05);
        chk("h31_halted", 32'(halted),      32'h1);
        cyc();
        chk("h32_valid", 32'(if_id_valid), 32'h0);
        chk("h32_en",    32'(imem_en),     32'h0);
        chk("h32_addr",  32'(imem_addr),   32'h05);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 4-bit-opcode core. Drives a synchronous-read instruction memory, sequences the PC, absorbs downstream stalls without losing in-flight words, squashes on taken branches, and stops on the HALT opcode. Its IF/ID outputs feed the decode stage directly: `opcode` and `reg_rt_id` go straight into `control_unit`.

## Interface
- `ADDR_WIDTH`, 8: instruction-memory word-address width; PC width.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `stall`  in  1: decode cannot accept; hold IF/ID contents.
- `branch_taken`  in  1: redirect fetch this cycle; overrides `stall`.
- `branch_target`  in  ADDR_WIDTH: new PC when `branch_taken`.
- `imem_en`  out  1: read request this cycle.
- `imem_addr`  out  ADDR_WIDTH: read address (= PC register).
- `imem_rdata`  in  16: word for the address requested in the previous cycle.
- `if_id_valid`  out  1: IF/ID holds a live instruction.
- `if_id_instr`  out  16: fetched instruction.
- `if_id_pc`  out  ADDR_WIDTH: address of `if_id_instr`.
- `opcode`  out  4: `if_id_instr[15:12]`.
- `reg_rt_id`  out  4: `if_id_instr[3:0]`; also the REGIMM sub-function.
- `halted`  out  1: sticky; HALT (opcode 4'b1111) reached IF/ID.

## Operation
- Instruction fields: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- State: `pc`, in-flight flag `f_valid` with `f_pc`, one-entry skid buffer (`sk_valid`, `sk_instr`, `sk_pc`), IF/ID registers, `halted`.
- `imem_en = ~reset & ~stall & ~branch_taken & ~halted` (combinational). On each issue: `pc <= pc + 1`, modulo 2^ADDR_WIDTH (wraps all-ones to 0); `f_valid <= 1`, `f_pc <= pc`. With no issue, `f_valid <= 0`.
- Cycle without stall or branch: IF/ID loads the skid entry if `sk_valid` (then clears it). Otherwise it loads the response if `f_valid`. Otherwise `if_id_valid <= 0`.
- Stall without branch: IF/ID holds and `pc` holds. A response arriving this cycle (`f_valid`) goes into the skid buffer. Because no request issues during stall, the skid buffer never overflows.
- Taken branch, any stall value: `pc <= branch_target`; `if_id_valid`, `sk_valid` and `f_valid` all cleared; no request this cycle.
- HALT: when an instruction with opcode 4'b1111 loads into IF/ID, `halted <= 1` on the same edge and the in-flight response is discarded.
  - The HALT word stays presented, held through any stall, until the first non-stalled cycle; after that `if_id_valid <= 0`.
  - After halting, `branch_taken` is ignored and no further requests issue until reset.
  - A HALT that would load in a branch cycle is squashed and does not set `halted`.
- Reset: `pc = RESET_PC`; `if_id_valid`, `f_valid`, `sk_valid`, `halted` = 0; `if_id_instr` = 16'h0000; `if_id_pc` = 0. `imem_en` = 0 during the reset cycle.

## Timing
- Memory latency is 1 cycle: address at cycle t, data on `imem_rdata` at t+1.
- Fetch-to-IF/ID is 2 cycles: request at t, IF/ID loaded at the end of t+1, visible at t+2.
- Steady-state throughput is 1 instruction/cycle after the first valid.
- Reset deasserted before cycle 0: request `RESET_PC` at cycle 0; `if_id_valid` first high at cycle 2.
- Branch penalty: `branch_taken` at t gives a target request at t+1 and the target instruction visible at t+3. IF/ID shows bubbles at t+1 and t+2.
- Stall released at t: if `sk_valid`, the skid word is visible at t+1, with a new request issuing at t. This preserves 1/cycle with no duplicate and no drop.
- Reset mid-operation overrides everything, including stall, branch and halted, on the same edge.

## Test plan
- Reset with `RESET_PC`=0 and memory holding words 0x0123, 0x3456, 0x7ABC at 0..2 -> `if_id_valid` rises at cycle 2; consecutive cycles show pc 0, 1, 2 with those words; `opcode` = 0, 3, 7; `reg_rt_id` = 3, 6, C.
- Stall asserted 3 cycles while a response is in flight -> IF/ID holds its word and pc for 3 cycles; on release, the next sequential word appears with no skipped or repeated PC.
- `branch_taken`=1 with `stall`=1 and target 0x40 while at pc 5 -> exactly 2 bubble cycles, then `if_id_pc`=0x40; neither the word from pc 5 nor the one from pc 6 ever appears valid.
- PC at 0xFF with `ADDR_WIDTH`=8 -> `if_id_pc` sequence 0xFE, 0xFF, 0x00, 0x01.
- HALT word 0xF000 at address 3, then a 2-cycle stall -> `halted`=1 when 0xF000 is presented; it is held for 2 cycles, then `if_id_valid`=0. `imem_en` stays 0, and a later `branch_taken` changes nothing.
- Reset asserted during a stall with `sk_valid`=1 -> the next cycle shows all valids 0, `halted`=0, `imem_addr`=`RESET_PC`; normal fetch resumes on deassert.
